// File: rtl/maze_framebuf.sv
// maze_framebuf: double-buffered 8x8 bicolour cell memory feeding the LED
// matrix scanner. The game writes into the back bank, the scanner reads the
// front bank, and a requested swap only lands on a scanner frame boundary.
// A built-in sweep clears the back bank one cell per cycle.
module maze_framebuf #(
  parameter int                 ADDR_W    = 6,
  parameter int                 DATA_W    = 2,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  input  logic              swap_req,
  input  logic              disp_active,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_sel,
  output logic              busy,
  output logic              swap_ack
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                front_q, front_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rd_q, rd_d;

  // back-bank write port, shared by pixel writes and the clear sweep
  logic                we;
  logic [ADDR_W-1:0]   wa;
  logic [DATA_W-1:0]   wd;

  logic [DATA_W-1:0]   bank0 [DEPTH];
  logic [DATA_W-1:0]   bank1 [DEPTH];

  // A frame boundary is the scanner fetching the last cell; an idle scanner
  // will never produce one, so a swap is allowed to land immediately.
  logic fire;
  assign fire = (rd_en && (rd_addr == '1)) || !disp_active;

  // Next-state, back-bank write selection and read mux
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    front_d = front_q;
    ack_d   = 1'b0;
    we      = 1'b0;
    wa      = wr_addr;
    wd      = wr_data;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (swap_req) begin
          state_d = SWAP_WAIT;
        end else if (wr_en) begin
          we = 1'b1;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        wa    = cnt_q;
        wd    = CLEAR_VAL;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      SWAP_WAIT: begin
        if (fire) begin
          front_d = ~front_q;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // read uses the current front bank, ahead of any same-cycle toggle
    rd_d = rd_q;
    if (rd_en) rd_d = front_q ? bank1[rd_addr] : bank0[rd_addr];
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      front_q <= 1'b0;
      ack_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      front_q <= front_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
  end

  // Cell storage: not reset, writes always go to the bank not on display
  always_ff @(posedge clk) begin
    if (we) begin
      if (front_q) bank0[wa] <= wd;
      else         bank1[wa] <= wd;
    end
  end

  assign rd_data   = rd_q;
  assign front_sel = front_q;
  assign swap_ack  = ack_q;
  assign busy      = (state_q != IDLE);

endmodule
